// File: rtl/input_conditioner.sv
// input_conditioner
// Board-side front end for the push-button and the slide switches. Each raw
// pin is brought into the clk domain through a SYNC_STAGES-deep flop chain.
// A counter-based debouncer then accepts a new level only after
// DEBOUNCE_CYCLES consecutive identical synchronised samples.
//
// The enter button has a 4-state FSM. It produces a clean level and a
// one-cycle press pulse. The switch vector is debounced as a whole, using
// one shared counter. Any bit that moves restarts the window for every bit.
// All outputs come straight from flops.

module input_conditioner #(
    parameter int SW_WIDTH        = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 2000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enter_raw,
    input  logic [SW_WIDTH-1:0] switch_raw,
    output logic                enter_level,
    output logic                enter_pulse,
    output logic [SW_WIDTH-1:0] switch_stable,
    output logic                switch_changed
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    // Last count value of the enter window. The 4th identical sample
    // arrives while cnt already holds D-1, because the first sample
    // moved the FSM into the wait state with cnt=1.
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    // The switch path needs one edge just to see ss equal to sprev.
    // Its counter therefore lags the enter counter by one, and it
    // accepts at D-2.
    localparam logic [CNT_W-1:0] SCNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_esync;
    logic [SW_WIDTH-1:0]    r_ssync [SYNC_STAGES];
    logic                   w_es;
    logic [SW_WIDTH-1:0]    w_ss;

    // Shift the raw button and switch pins through the synchroniser chains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_esync <= {SYNC_STAGES{1'b0}};
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_ssync[i] <= {SW_WIDTH{1'b0}};
            end
        end else begin
            r_esync    <= {r_esync[SYNC_STAGES-2:0], enter_raw};
            r_ssync[0] <= switch_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_ssync[i] <= r_ssync[i-1];
            end
        end
    end

    assign w_es = r_esync[SYNC_STAGES-1];
    assign w_ss = r_ssync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Enter debouncer FSM
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_pulse;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_level_nxt;
    logic             w_pulse_nxt;

    // Next-state logic for the enter FSM. The pulse is only ever raised
    // on the PRESS_WAIT -> PRESSED edge, so a held button yields one pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_pulse_nxt = 1'b0;
        case (r_state)
            ST_RELEASED: begin
                w_level_nxt = 1'b0;
                if (w_es) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            ST_PRESS_WAIT: begin
                if (!w_es) begin
                    w_state_nxt = ST_RELEASED;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt >= CNT_LAST) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = CNT_ZERO;
                    w_level_nxt = 1'b1;
                    w_pulse_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                w_level_nxt = 1'b1;
                if (!w_es) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            ST_RELEASE_WAIT: begin
                if (w_es) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt >= CNT_LAST) begin
                    w_state_nxt = ST_RELEASED;
                    w_cnt_nxt   = CNT_ZERO;
                    w_level_nxt = 1'b0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_RELEASED;
                w_cnt_nxt   = CNT_ZERO;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    // Register the enter FSM state, the counter and the level/pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RELEASED;
            r_cnt   <= CNT_ZERO;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Switch vector debouncer
    // ------------------------------------------------------------------
    logic [SW_WIDTH-1:0] r_sprev;
    logic [SW_WIDTH-1:0] r_sstable;
    logic                r_schanged;
    logic [CNT_W-1:0]    r_scnt;

    logic [SW_WIDTH-1:0] w_sstable_nxt;
    logic                w_schanged_nxt;
    logic [CNT_W-1:0]    w_scnt_nxt;

    // Whole-vector debounce. Any difference from the previous sample
    // restarts the window. A vector that drifts back to the accepted
    // value before the window closes is dropped silently.
    always_comb begin
        w_sstable_nxt  = r_sstable;
        w_schanged_nxt = 1'b0;
        w_scnt_nxt     = r_scnt;
        if (w_ss != r_sprev) begin
            w_scnt_nxt = CNT_ZERO;
        end else if (w_ss != r_sstable) begin
            if (r_scnt >= SCNT_LAST) begin
                w_sstable_nxt  = w_ss;
                w_schanged_nxt = 1'b1;
                w_scnt_nxt     = CNT_ZERO;
            end else begin
                w_scnt_nxt     = r_scnt + CNT_ONE;
            end
        end else begin
            w_scnt_nxt = CNT_ZERO;
        end
    end

    // Register the previous sample, the shared counter and the switch outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sprev    <= {SW_WIDTH{1'b0}};
            r_sstable  <= {SW_WIDTH{1'b0}};
            r_schanged <= 1'b0;
            r_scnt     <= CNT_ZERO;
        end else begin
            r_sprev    <= w_ss;
            r_sstable  <= w_sstable_nxt;
            r_schanged <= w_schanged_nxt;
            r_scnt     <= w_scnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all flop-driven)
    // ------------------------------------------------------------------
    assign enter_level    = r_level;
    assign enter_pulse    = r_pulse;
    assign switch_stable  = r_sstable;
    assign switch_changed = r_schanged;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Expected pulses are queued with their due edge when stimulus is driven.
// They are popped and compared when the DUT raises a pulse.
// An input driven just after edge k is sampled at edge k+1. Its accepted
// output therefore appears at edge k+1+2+4-1 = k+6.

module tb_input_conditioner;

    localparam int LAT = 6;

    typedef struct {
        int          edge_n;
        logic [15:0] val;
    } sw_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enter_raw;
    logic [15:0] switch_raw;
    logic        enter_level;
    logic        enter_pulse;
    logic [15:0] switch_stable;
    logic        switch_changed;

    int      cyc   = 0;
    int      n_cmp = 0;
    int      n_err = 0;
    int      exp_ent [$];
    sw_exp_t exp_sw  [$];
    bit      bounce_pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    input_conditioner #(
        .SW_WIDTH        (16),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enter_raw      (enter_raw),
        .switch_raw     (switch_raw),
        .enter_level    (enter_level),
        .enter_pulse    (enter_pulse),
        .switch_stable  (switch_stable),
        .switch_changed (switch_changed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enter_raw = 1'b1; switch_raw = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({enter_level, enter_pulse, switch_stable, switch_changed} !== 19'd0) begin
                n_err++;
                $display("FAIL reset_outputs: edge %0d got el=%b ep=%b ss=%h sc=%b, required all 0",
                         cyc, enter_level, enter_pulse, switch_stable, switch_changed);
            end
        end
        rst = 1'b0;
        exp_ent.push_back(cyc + LAT);
        exp_sw.push_back('{cyc + LAT, 16'hFFFF});
    endtask

    task automatic test_clean_press();
        int      exp_e;
        sw_exp_t exp_s;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (enter_pulse === 1'b1) begin
                n_cmp++;
                if (exp_ent.size() == 0) begin
                    n_err++; $display("FAIL clean_press enter_pulse: pulse at edge %0d, required none", cyc);
                end else begin
                    exp_e = exp_ent.pop_front();
                    if (cyc !== exp_e || enter_level !== 1'b1) begin
                        n_err++; $display("FAIL clean_press enter_pulse: edge %0d level %b, required edge %0d level 1", cyc, enter_level, exp_e);
                    end
                end
            end else if (exp_ent.size() != 0 && exp_ent[0] <= cyc) begin
                n_cmp++; n_err++; exp_e = exp_ent.pop_front();
                $display("FAIL clean_press enter_pulse: none by edge %0d, required at edge %0d", cyc, exp_e);
            end
            if (switch_changed === 1'b1) begin
                n_cmp++;
                if (exp_sw.size() == 0) begin
                    n_err++; $display("FAIL clean_press switch_changed: pulse at edge %0d value %h, required none", cyc, switch_stable);
                end else begin
                    exp_s = exp_sw.pop_front();
                    if (cyc !== exp_s.edge_n || switch_stable !== exp_s.val) begin
                        n_err++; $display("FAIL clean_press switch_changed: edge %0d value %h, required edge %0d value %h", cyc, switch_stable, exp_s.edge_n, exp_s.val);
                    end
                end
            end else if (exp_sw.size() != 0 && exp_sw[0].edge_n <= cyc) begin
                n_cmp++; n_err++; exp_s = exp_sw.pop_front();
                $display("FAIL clean_press switch_changed: none by edge %0d, required at edge %0d", cyc, exp_s.edge_n);
            end
        end
        n_cmp++;
        if (enter_level !== 1'b1 || switch_stable !== 16'hFFFF) begin
            n_err++; $display("FAIL clean_press final: level %b stable %h, required 1 / ffff", enter_level, switch_stable);
        end
    endtask

    task automatic test_bounce();
        int      exp_e;
        sw_exp_t exp_s;
        for (int i = 0; i < 40; i++) begin
            if (i == 0) begin
                enter_raw = 1'b0; switch_raw = 16'h0000;
                exp_sw.push_back('{cyc + LAT, 16'h0000});
            end else if (i >= 12 && i < 18) begin
                enter_raw = bounce_pat[i-12];
            end else if (i == 18) begin
                enter_raw = 1'b1;
                exp_ent.push_back(cyc + LAT);
            end
            tick();
            if (enter_pulse === 1'b1) begin
                n_cmp++;
                if (exp_ent.size() == 0) begin
                    n_err++; $display("FAIL bounce enter_pulse: pulse at edge %0d, required none", cyc);
                end else begin
                    exp_e = exp_ent.pop_front();
                    if (cyc !== exp_e || enter_level !== 1'b1) begin
                        n_err++; $display("FAIL bounce enter_pulse: edge %0d level %b, required edge %0d level 1", cyc, enter_level, exp_e);
                    end
                end
            end else if (exp_ent.size() != 0 && exp_ent[0] <= cyc) begin
                n_cmp++; n_err++; exp_e = exp_ent.pop_front();
                $display("FAIL bounce enter_pulse: none by edge %0d, required at edge %0d", cyc, exp_e);
            end
            if (switch_changed === 1'b1) begin
                n_cmp++;
                if (exp_sw.size() == 0) begin
                    n_err++; $display("FAIL bounce switch_changed: pulse at edge %0d value %h, required none", cyc, switch_stable);
                end else begin
                    exp_s = exp_sw.pop_front();
                    if (cyc !== exp_s.edge_n || switch_stable !== exp_s.val) begin
                        n_err++; $display("FAIL bounce switch_changed: edge %0d value %h, required edge %0d value %h", cyc, switch_stable, exp_s.edge_n, exp_s.val);
                    end
                end
            end else if (exp_sw.size() != 0 && exp_sw[0].edge_n <= cyc) begin
                n_cmp++; n_err++; exp_s = exp_sw.pop_front();
                $display("FAIL bounce switch_changed: none by edge %0d, required at edge %0d", cyc, exp_s.edge_n);
            end
            if (i == 11) begin
                n_cmp++;
                if (enter_level !== 1'b0 || switch_stable !== 16'h0000) begin
                    n_err++; $display("FAIL bounce released: level %b stable %h, required 0 / 0000", enter_level, switch_stable);
                end
            end
        end
        n_cmp++;
        if (enter_level !== 1'b1) begin
            n_err++; $display("FAIL bounce final_level: got %b, required 1", enter_level);
        end
    endtask

    task automatic test_release_repress();
        int exp_e;
        for (int i = 0; i < 40; i++) begin
            if (i == 0)       enter_raw = 1'b0;
            else if (i == 2)  enter_raw = 1'b1;
            else if (i == 12) enter_raw = 1'b0;
            else if (i == 20) begin
                enter_raw = 1'b1;
                exp_ent.push_back(cyc + LAT);
            end
            tick();
            if (enter_pulse === 1'b1) begin
                n_cmp++;
                if (exp_ent.size() == 0) begin
                    n_err++; $display("FAIL release_repress enter_pulse: pulse at edge %0d, required none", cyc);
                end else begin
                    exp_e = exp_ent.pop_front();
                    if (cyc !== exp_e || enter_level !== 1'b1) begin
                        n_err++; $display("FAIL release_repress enter_pulse: edge %0d level %b, required edge %0d level 1", cyc, enter_level, exp_e);
                    end
                end
            end else if (exp_ent.size() != 0 && exp_ent[0] <= cyc) begin
                n_cmp++; n_err++; exp_e = exp_ent.pop_front();
                $display("FAIL release_repress enter_pulse: none by edge %0d, required at edge %0d", cyc, exp_e);
            end
            if (switch_changed === 1'b1) begin
                n_cmp++; n_err++;
                $display("FAIL release_repress switch_changed: pulse at edge %0d, required none", cyc);
            end
            if (i < 12) begin
                n_cmp++;
                if (enter_level !== 1'b1) begin
                    n_err++; $display("FAIL release_repress short_release: edge %0d level %b, required 1", cyc, enter_level);
                end
            end else if (i == 19) begin
                n_cmp++;
                if (enter_level !== 1'b0) begin
                    n_err++; $display("FAIL release_repress long_release: level %b, required 0", enter_level);
                end
            end
        end
        n_cmp++;
        if (enter_level !== 1'b1) begin
            n_err++; $display("FAIL release_repress final_level: got %b, required 1", enter_level);
        end
    endtask

    task automatic test_switch();
        sw_exp_t exp_s;
        for (int i = 0; i < 40; i++) begin
            if (i == 0) begin
                switch_raw = 16'h00A5; exp_sw.push_back('{cyc + LAT, 16'h00A5});
            end else if (i == 10) begin
                switch_raw = 16'h0000; exp_sw.push_back('{cyc + LAT, 16'h0000});
            end else if (i == 20) begin
                switch_raw = 16'h00A5;
            end else if (i == 22) begin
                switch_raw = 16'h00A4;
            end else if (i == 23) begin
                switch_raw = 16'h00A5; exp_sw.push_back('{cyc + LAT, 16'h00A5});
            end
            tick();
            if (enter_pulse === 1'b1) begin
                n_cmp++; n_err++;
                $display("FAIL switch enter_pulse: pulse at edge %0d, required none", cyc);
            end
            if (switch_changed === 1'b1) begin
                n_cmp++;
                if (exp_sw.size() == 0) begin
                    n_err++; $display("FAIL switch switch_changed: pulse at edge %0d value %h, required none", cyc, switch_stable);
                end else begin
                    exp_s = exp_sw.pop_front();
                    if (cyc !== exp_s.edge_n || switch_stable !== exp_s.val) begin
                        n_err++; $display("FAIL switch switch_changed: edge %0d value %h, required edge %0d value %h", cyc, switch_stable, exp_s.edge_n, exp_s.val);
                    end
                end
            end else if (exp_sw.size() != 0 && exp_sw[0].edge_n <= cyc) begin
                n_cmp++; n_err++; exp_s = exp_sw.pop_front();
                $display("FAIL switch switch_changed: none by edge %0d, required at edge %0d", cyc, exp_s.edge_n);
            end
            if (i == 9 || i == 19) begin
                n_cmp++;
                if (switch_stable !== ((i == 9) ? 16'h00A5 : 16'h0000)) begin
                    n_err++; $display("FAIL switch stable_mid: edge %0d value %h", cyc, switch_stable);
                end
            end
        end
        n_cmp++;
        if (switch_stable !== 16'h00A5) begin
            n_err++; $display("FAIL switch final_stable: got %h, required 00a5", switch_stable);
        end
    endtask

    task automatic test_simultaneous();
        int      exp_e;
        sw_exp_t exp_s;
        for (int i = 0; i < 30; i++) begin
            if (i == 0) begin
                enter_raw = 1'b0;
            end else if (i == 10) begin
                enter_raw = 1'b1; switch_raw = 16'h3C3C;
                exp_ent.push_back(cyc + LAT);
                exp_sw.push_back('{cyc + LAT, 16'h3C3C});
            end
            tick();
            if (enter_pulse === 1'b1) begin
                n_cmp++;
                if (exp_ent.size() == 0) begin
                    n_err++; $display("FAIL simultaneous enter_pulse: pulse at edge %0d, required none", cyc);
                end else begin
                    exp_e = exp_ent.pop_front();
                    if (cyc !== exp_e || enter_level !== 1'b1 || switch_changed !== 1'b1) begin
                        n_err++; $display("FAIL simultaneous enter_pulse: edge %0d level %b sc %b, required edge %0d level 1 sc 1", cyc, enter_level, switch_changed, exp_e);
                    end
                end
            end else if (exp_ent.size() != 0 && exp_ent[0] <= cyc) begin
                n_cmp++; n_err++; exp_e = exp_ent.pop_front();
                $display("FAIL simultaneous enter_pulse: none by edge %0d, required at edge %0d", cyc, exp_e);
            end
            if (switch_changed === 1'b1) begin
                n_cmp++;
                if (exp_sw.size() == 0) begin
                    n_err++; $display("FAIL simultaneous switch_changed: pulse at edge %0d value %h, required none", cyc, switch_stable);
                end else begin
                    exp_s = exp_sw.pop_front();
                    if (cyc !== exp_s.edge_n || switch_stable !== exp_s.val) begin
                        n_err++; $display("FAIL simultaneous switch_changed: edge %0d value %h, required edge %0d value %h", cyc, switch_stable, exp_s.edge_n, exp_s.val);
                    end
                end
            end else if (exp_sw.size() != 0 && exp_sw[0].edge_n <= cyc) begin
                n_cmp++; n_err++; exp_s = exp_sw.pop_front();
                $display("FAIL simultaneous switch_changed: none by edge %0d, required at edge %0d", cyc, exp_s.edge_n);
            end
            if (i == 9) begin
                n_cmp++;
                if (enter_level !== 1'b0) begin
                    n_err++; $display("FAIL simultaneous released: level %b, required 0", enter_level);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 30; i++) begin
            if (i == 0) begin
                enter_raw = 1'b0;
            end else if (i == 10) begin
                enter_raw = 1'b1; switch_raw = 16'h0F0F;
            end else if (i == 14) begin
                rst = 1'b1;
            end else if (i == 16) begin
                rst = 1'b0; enter_raw = 1'b0; switch_raw = 16'h0000;
            end
            tick();
            if (enter_pulse === 1'b1 || switch_changed === 1'b1) begin
                n_cmp++; n_err++;
                $display("FAIL reset_mid pulse: edge %0d ep %b sc %b, required none", cyc, enter_pulse, switch_changed);
            end
            if (i == 14 || i == 15 || i == 29) begin
                n_cmp++;
                if ({enter_level, enter_pulse, switch_stable, switch_changed} !== 19'd0) begin
                    n_err++; $display("FAIL reset_mid outputs: edge %0d el=%b ss=%h, required all 0", cyc, enter_level, switch_stable);
                end
            end
        end
        n_cmp++;
        if (exp_ent.size() != 0 || exp_sw.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: %0d enter / %0d switch left, required 0 / 0", exp_ent.size(), exp_sw.size());
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_repress();
        test_switch();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
